// File: rtl/ldpc_pkg.sv
// Shared widths, sync nibble and FSM state types for the LDPC front end.
package ldpc_pkg;

    localparam int unsigned CODE_W = 12;
    localparam int unsigned MSG_W  = 4;

    localparam logic [MSG_W-1:0] SYNC_NIB = 4'hA;

    typedef enum logic {
        A_HI,
        A_LO
    } asm_state_t;

    typedef enum logic {
        L_IDLE,
        L_BUSY
    } launch_state_t;

endpackage

// File: rtl/ldpc_cnt_timer.sv
// Saturating timeout counter with clear/enable and a one-cycle expire flag.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the count (takes priority over en)
//   en         : count this cycle
//   limit      : timeout length in enabled cycles
//   expire_c   : combinational, high on the enabled cycle where count == limit-1
module ldpc_cnt_timer #(
    parameter int unsigned TMR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [TMR_W-1:0] limit,
    output logic             expire_c
);

    logic [TMR_W-1:0] count;

    // Count up while enabled, holding at limit instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count < limit)) begin
            count <= count + TMR_W'(1);
        end
    end

    assign expire_c = en && !clr && (count == (limit - TMR_W'(1)));

endmodule

// File: rtl/ldpc_code_assembler.sv
// Assembles header/payload UART bytes into 12-bit codewords, buffers one
// codeword and launches it to the LDPC decoder when the decoder is idle.
//   rx_data/rx_done : received byte and its one-cycle strobe
//   dec_tx_en       : decoder finished pulse
//   code            : codeword held for the decoder, updated only at launch
//   num_done        : one-cycle decode start pulse
//   busy            : decode in flight
//   frame_err       : pulse on bad header or inter-byte timeout
//   overrun         : pulse when a finished frame is dropped (buffer full)
//   dec_timeout     : pulse when the decoder watchdog expires
module ldpc_code_assembler #(
    parameter logic [3:0]  SYNC_NIB     = ldpc_pkg::SYNC_NIB,
    parameter int unsigned BYTE_TIMEOUT = 5000,
    parameter int unsigned DEC_TIMEOUT  = 64,
    parameter int unsigned TMR_W        = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_done,
    input  logic                        dec_tx_en,
    output logic [ldpc_pkg::CODE_W-1:0] code,
    output logic                        num_done,
    output logic                        busy,
    output logic                        frame_err,
    output logic                        overrun,
    output logic                        dec_timeout
);

    import ldpc_pkg::*;

    localparam logic [TMR_W-1:0] BYTE_LIM = TMR_W'(BYTE_TIMEOUT);
    localparam logic [TMR_W-1:0] DEC_LIM  = TMR_W'(DEC_TIMEOUT);

    asm_state_t          a_state;
    launch_state_t       l_state;
    logic [MSG_W-1:0]    hi_nib;
    logic [CODE_W-1:0]   pend;
    logic                pend_valid;

    logic hdr_ok_c;
    logic launch_c;
    logic byte_clr_c;
    logic byte_en_c;
    logic byte_exp_c;
    logic wdog_en_c;
    logic wdog_exp_c;

    assign hdr_ok_c   = (rx_data[7:4] == SYNC_NIB);
    // Buffer is consumed on any edge where the launcher is idle with data waiting.
    assign launch_c   = (l_state == L_IDLE) && pend_valid;
    assign byte_clr_c = (a_state == A_HI) && rx_done && hdr_ok_c;
    assign byte_en_c  = (a_state == A_LO);
    assign wdog_en_c  = (l_state == L_BUSY);

    ldpc_cnt_timer #(.TMR_W(TMR_W)) u_byte_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (byte_clr_c),
        .en       (byte_en_c),
        .limit    (BYTE_LIM),
        .expire_c (byte_exp_c)
    );

    ldpc_cnt_timer #(.TMR_W(TMR_W)) u_dec_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (launch_c),
        .en       (wdog_en_c),
        .limit    (DEC_LIM),
        .expire_c (wdog_exp_c)
    );

    // Assembly FSM: header nibble, then payload byte into the one-deep buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_state    <= A_HI;
            hi_nib     <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (launch_c) begin
                pend_valid <= 1'b0;
            end
            case (a_state)
                A_HI: begin
                    if (rx_done) begin
                        if (hdr_ok_c) begin
                            hi_nib  <= rx_data[3:0];
                            a_state <= A_LO;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                A_LO: begin
                    // A payload arriving on the timeout cycle still completes the frame.
                    if (rx_done) begin
                        a_state <= A_HI;
                        if (!pend_valid || launch_c) begin
                            pend       <= {hi_nib, rx_data};
                            pend_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (byte_exp_c) begin
                        frame_err <= 1'b1;
                        a_state   <= A_HI;
                    end
                end
                default: a_state <= A_HI;
            endcase
        end
    end

    // Launch FSM: present the buffered word, then wait for decoder or watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_state     <= L_IDLE;
            code        <= '0;
            num_done    <= 1'b0;
            busy        <= 1'b0;
            dec_timeout <= 1'b0;
        end else begin
            num_done    <= 1'b0;
            dec_timeout <= 1'b0;
            case (l_state)
                L_IDLE: begin
                    if (pend_valid) begin
                        code     <= pend;
                        num_done <= 1'b1;
                        busy     <= 1'b1;
                        l_state  <= L_BUSY;
                    end
                end
                L_BUSY: begin
                    if (dec_tx_en) begin
                        busy    <= 1'b0;
                        l_state <= L_IDLE;
                    end else if (wdog_exp_c) begin
                        dec_timeout <= 1'b1;
                        busy        <= 1'b0;
                        l_state     <= L_IDLE;
                    end
                end
                default: l_state <= L_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_code_assembler.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// cycle by cycle against a timestamp/queue reference model.
module tb_ldpc_code_assembler;

    localparam int unsigned BT = 5000;
    localparam int unsigned DT = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        dec_tx_en;
    logic [11:0] code;
    logic        num_done;
    logic        busy;
    logic        frame_err;
    logic        overrun;
    logic        dec_timeout;

    int vectors = 0;
    int miscompares = 0;

    ldpc_code_assembler #(
        .SYNC_NIB     (4'hA),
        .BYTE_TIMEOUT (BT),
        .DEC_TIMEOUT  (DT),
        .TMR_W        (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .dec_tx_en   (dec_tx_en),
        .code        (code),
        .num_done    (num_done),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .dec_timeout (dec_timeout)
    );

    always #10 clk = ~clk;

    // Reference model: frame start time, one-deep buffer queue, decode start time.
    int          m_cyc;
    bit          m_in_frame;
    int          m_hdr;
    logic [3:0]  m_hi;
    logic [11:0] pend_q[$];
    bit          m_busy;
    int          m_launch;
    logic [11:0] e_code;
    bit          e_nd, e_ferr, e_ovr, e_dto;

    task automatic model_reset();
        m_in_frame = 0;
        m_busy     = 0;
        pend_q.delete();
        e_code = 12'h000;
        e_nd = 0; e_ferr = 0; e_ovr = 0; e_dto = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit t);
        m_cyc++;
        e_nd = 0; e_ferr = 0; e_ovr = 0; e_dto = 0;
        if (!m_busy && pend_q.size() > 0) begin
            e_code   = pend_q.pop_front();
            e_nd     = 1;
            m_busy   = 1;
            m_launch = m_cyc;
        end else if (m_busy) begin
            if (t) m_busy = 0;
            else if (m_cyc - m_launch == int'(DT)) begin
                e_dto  = 1;
                m_busy = 0;
            end
        end
        if (!m_in_frame) begin
            if (v) begin
                if (d[7:4] == 4'hA) begin
                    m_in_frame = 1;
                    m_hdr      = m_cyc;
                    m_hi       = d[3:0];
                end else begin
                    e_ferr = 1;
                end
            end
        end else if (v) begin
            m_in_frame = 0;
            if (pend_q.size() == 0) pend_q.push_back({m_hi, d});
            else e_ovr = 1;
        end else if (m_cyc - m_hdr == int'(BT)) begin
            e_ferr     = 1;
            m_in_frame = 0;
        end
    endtask

    function automatic logic [16:0] dut_vec();
        return {code, num_done, busy, frame_err, overrun, dec_timeout};
    endfunction

    function automatic logic [16:0] model_vec();
        return {e_code, e_nd, m_busy, e_ferr, e_ovr, e_dto};
    endfunction

    // Drive one cycle of inputs, step the model on the edge, return at negedge.
    task automatic tick(input bit v, input logic [7:0] d, input bit t);
        rx_done   = v;
        rx_data   = d;
        dec_tx_en = t;
        @(posedge clk);
        model_step(v, d, t);
        @(negedge clk);
        rx_done   = 1'b0;
        dec_tx_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00; dec_tx_en = 1'b0;
        model_reset();
        m_cyc = 0;
        repeat (3) @(negedge clk);
        if (dut_vec() !== 17'h0) begin
            $display("FAIL reset_hold: got %h expected %h", dut_vec(), 17'h0); miscompares++;
        end
        vectors++;
        rst_n = 1'b1;
        repeat (3) begin
            tick(0, 8'h00, 0);
            if (dut_vec() !== model_vec()) begin
                $display("FAIL reset_idle: got %h expected %h", dut_vec(), model_vec()); miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_normal();
        logic [7:0] bytes[3] = '{8'hA9, 8'h00, 8'h3C};
        bit         strb[3]  = '{1, 0, 1};
        for (int i = 0; i < 3; i++) begin
            tick(strb[i], bytes[i], 0);
            if (dut_vec() !== model_vec()) begin
                $display("FAIL normal_rx: got %h expected %h", dut_vec(), model_vec()); miscompares++;
            end
            vectors++;
        end
        if (num_done !== 1'b0) begin
            $display("FAIL normal_nd_early: got %b expected 0", num_done); miscompares++;
        end
        vectors++;
        tick(0, 8'h00, 0);
        if ({code, num_done, busy} !== {12'h93C, 1'b1, 1'b1}) begin
            $display("FAIL normal_launch: got %h expected %h", {code, num_done, busy}, {12'h93C, 2'b11}); miscompares++;
        end
        vectors++;
        for (int i = 0; i < 29; i++) begin
            tick(0, 8'h00, i == 28);
            if (dut_vec() !== model_vec()) begin
                $display("FAIL normal_busy: got %h expected %h", dut_vec(), model_vec()); miscompares++;
            end
            vectors++;
        end
        if ({busy, frame_err, overrun, dec_timeout} !== 4'b0000) begin
            $display("FAIL normal_done: got %b expected 0000", {busy, frame_err, overrun, dec_timeout}); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_bad_header();
        logic [7:0] bytes[3] = '{8'h59, 8'h00, 8'h3C};
        bit         strb[3]  = '{1, 0, 1};
        for (int i = 0; i < 3; i++) begin
            tick(strb[i], bytes[i], 0);
            if (frame_err !== strb[i]) begin
                $display("FAIL bad_hdr_ferr: got %b expected %b", frame_err, strb[i]); miscompares++;
            end
            vectors++;
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 8'h00, 0);
            if ({code, num_done} !== {12'h93C, 1'b0}) begin
                $display("FAIL bad_hdr_code: got %h expected %h", {code, num_done}, {12'h93C, 1'b0}); miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_byte_timeout();
        int ferr_cnt = 0;
        tick(1, 8'hA1, 0);
        for (int i = 0; i < int'(BT); i++) begin
            tick(0, 8'h00, 0);
            if (frame_err) ferr_cnt++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL tmo_wait cyc %0d: got %h expected %h", i, dut_vec(), model_vec()); miscompares++;
            end
            vectors++;
        end
        if (ferr_cnt != 1 || frame_err !== 1'b1) begin
            $display("FAIL tmo_ferr: got count %0d last %b expected count 1 last 1", ferr_cnt, frame_err); miscompares++;
        end
        vectors++;
        tick(1, 8'hA2, 0);
        tick(1, 8'h55, 0);
        tick(0, 8'h00, 0);
        if ({code, num_done} !== {12'h255, 1'b1}) begin
            $display("FAIL tmo_next: got %h expected %h", {code, num_done}, {12'h255, 1'b1}); miscompares++;
        end
        vectors++;
        repeat (5) tick(0, 8'h00, 0);
        tick(0, 8'h00, 1);
        if (busy !== 1'b0) begin
            $display("FAIL tmo_release: got %b expected 0", busy); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[6] = '{8'hA1, 8'h11, 8'hA2, 8'h22, 8'hA3, 8'h33};
        for (int i = 0; i < 6; i++) begin
            tick(1, bytes[i], 0);
            if (dut_vec() !== model_vec()) begin
                $display("FAIL b2b_byte %0d: got %h expected %h", i, dut_vec(), model_vec()); miscompares++;
            end
            vectors++;
            tick(0, 8'h00, 0);
            if (i == 1 && {code, num_done} !== {12'h111, 1'b1}) begin
                $display("FAIL b2b_first: got %h expected %h", {code, num_done}, {12'h111, 1'b1}); miscompares++;
            end
            if (i == 1) vectors++;
        end
        // The A3/33 frame finished on the edge before the last idle tick above.
        tick(0, 8'h00, 0);
        tick(0, 8'h00, 1);
        if ({busy, num_done, code} !== {1'b0, 1'b0, 12'h111}) begin
            $display("FAIL b2b_release: got %h expected %h", {busy, num_done, code}, {2'b00, 12'h111}); miscompares++;
        end
        vectors++;
        tick(0, 8'h00, 0);
        if ({code, num_done, busy} !== {12'h222, 1'b1, 1'b1}) begin
            $display("FAIL b2b_second: got %h expected %h", {code, num_done, busy}, {12'h222, 2'b11}); miscompares++;
        end
        vectors++;
        repeat (3) tick(0, 8'h00, 0);
        tick(0, 8'h00, 1);
        if (dut_vec() !== model_vec()) begin
            $display("FAIL b2b_end: got %h expected %h", dut_vec(), model_vec()); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_overrun_pulse();
        int ovr_cnt = 0;
        tick(1, 8'hA1, 0); tick(1, 8'h11, 0);
        tick(1, 8'hA2, 0); tick(1, 8'h22, 0);
        tick(1, 8'hA3, 0); tick(1, 8'h33, 0);
        if (overrun) ovr_cnt++;
        tick(0, 8'h00, 0);
        if (overrun) ovr_cnt++;
        if (ovr_cnt != 1) begin
            $display("FAIL ovr_count: got %0d expected 1", ovr_cnt); miscompares++;
        end
        vectors++;
        tick(0, 8'h00, 1);
        tick(0, 8'h00, 0);
        if ({code, num_done} !== {12'h222, 1'b1}) begin
            $display("FAIL ovr_next: got %h expected %h", {code, num_done}, {12'h222, 1'b1}); miscompares++;
        end
        vectors++;
        tick(0, 8'h00, 1);
        tick(0, 8'h00, 0);
    endtask

    task automatic test_watchdog();
        tick(1, 8'hA4, 0);
        tick(1, 8'h44, 0);
        tick(0, 8'h00, 0);
        if ({code, num_done} !== {12'h444, 1'b1}) begin
            $display("FAIL wdog_launch: got %h expected %h", {code, num_done}, {12'h444, 1'b1}); miscompares++;
        end
        vectors++;
        for (int k = 1; k <= int'(DT); k++) begin
            tick(k <= 2, (k == 1) ? 8'hA5 : 8'h55, 0);
            if (dut_vec() !== model_vec()) begin
                $display("FAIL wdog_cyc %0d: got %h expected %h", k, dut_vec(), model_vec()); miscompares++;
            end
            vectors++;
            if (k == int'(DT) - 1 && {dec_timeout, busy} !== 2'b01) begin
                $display("FAIL wdog_early: got %b expected 01", {dec_timeout, busy}); miscompares++;
            end
            if (k == int'(DT) && {dec_timeout, busy} !== 2'b10) begin
                $display("FAIL wdog_fire: got %b expected 10", {dec_timeout, busy}); miscompares++;
            end
        end
        tick(0, 8'h00, 0);
        if ({code, num_done, dec_timeout} !== {12'h555, 1'b1, 1'b0}) begin
            $display("FAIL wdog_next: got %h expected %h", {code, num_done, dec_timeout}, {12'h555, 2'b10}); miscompares++;
        end
        vectors++;
        tick(0, 8'h00, 1);
        tick(0, 8'h00, 0);
    endtask

    task automatic test_async_reset();
        // Reset between header and payload.
        tick(1, 8'hA7, 0);
        #2 rst_n = 1'b0;
        #1;
        if (dut_vec() !== 17'h0) begin
            $display("FAIL arst_frame: got %h expected %h", dut_vec(), 17'h0); miscompares++;
        end
        vectors++;
        model_reset();
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        // The orphan payload now arrives as a header and must be rejected.
        tick(1, 8'h77, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 8'h00, 0);
            if (dut_vec() !== model_vec()) begin
                $display("FAIL arst_after1: got %h expected %h", dut_vec(), model_vec()); miscompares++;
            end
            vectors++;
        end
        // Reset during a decode.
        tick(1, 8'hA8, 0); tick(1, 8'h88, 0); tick(0, 8'h00, 0);
        tick(0, 8'h00, 0);
        #2 rst_n = 1'b0;
        #1;
        if (dut_vec() !== 17'h0) begin
            $display("FAIL arst_busy: got %h expected %h", dut_vec(), 17'h0); miscompares++;
        end
        vectors++;
        model_reset();
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(0, 8'h00, 0);
            if (num_done !== 1'b0) begin
                $display("FAIL arst_spurious: got %b expected 0", num_done); miscompares++;
            end
            vectors++;
        end
        tick(1, 8'hA6, 0); tick(1, 8'h66, 0); tick(0, 8'h00, 0);
        if ({code, num_done, busy} !== {12'h666, 1'b1, 1'b1}) begin
            $display("FAIL arst_recover: got %h expected %h", {code, num_done, busy}, {12'h666, 2'b11}); miscompares++;
        end
        vectors++;
        tick(0, 8'h00, 1);
        tick(0, 8'h00, 0);
    endtask

    task automatic test_random();
        bit         v, t;
        logic [7:0] d;
        for (int i = 0; i < 4000; i++) begin
            v = ($urandom % 4) == 0;
            d = 8'($urandom);
            if (($urandom % 6) != 0) d[7:4] = 4'hA;
            t = m_busy ? (($urandom % 40) == 0) : (($urandom % 50) == 0);
            tick(v, d, t);
            if (dut_vec() !== model_vec()) begin
                $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec(), model_vec()); miscompares++;
            end
            vectors++;
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bad_header();
        test_byte_timeout();
        test_back_to_back();
        test_overrun_pulse();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
